scan_sequencer: RTL and testbench
=================================

# scan_sequencer

Upstream feeder for the signature-detection FSM. Walks a window of the 1-bit signature/sample ROM, compensates for the ROM read latency, and presents one bit per cycle on a valid/ready stream. Each bit is tagged with its ROM address and an end-of-scan marker. The detector consumes this stream, so it no longer drives ROM addresses itself.

## Interface
- ADDR_W, 12, ROM address width.
- DEPTH, 4096, ROM depth in bits; addresses wrap modulo DEPTH.
- READ_LAT, 1, ROM read latency in cycles from mem_en_o/mem_addr_o to mem_data_i; legal values are 1 and 2.

- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-low.
- start_i  in  1  scan request; sampled only in IDLE.
- abort_i  in  1  stop the current scan immediately.
- base_i  in  ADDR_W  first ROM address, latched on start.
- len_i  in  ADDR_W+1  number of bits to scan, latched on start.
- mem_en_o  out  1  ROM read enable.
- mem_addr_o  out  ADDR_W  ROM read address.
- mem_data_i  in  1  ROM read data, valid READ_LAT cycles after a read is issued.
- bit_o  out  1  stream data.
- bit_addr_o  out  ADDR_W  ROM address of bit_o.
- bit_last_o  out  1  bit_o is the final bit of the scan.
- bit_valid_o  out  1  stream valid.
- bit_ready_i  in  1  downstream ready.
- busy_o  out  1  scan in progress (RUN or DRAIN).
- done_o  out  1  one-cycle pulse when a scan completes normally.
- err_o  out  1  one-cycle pulse when a start request is rejected.

## Operation
- States and transitions:
  - IDLE: start_i with 1 ≤ len_i ≤ DEPTH moves to RUN and latches base/len. start_i with len_i = 0 or len_i > DEPTH pulses err_o and stays in IDLE.
  - RUN: issues reads. Moves to DRAIN once the issued-read count reaches len.
  - DRAIN: waits until no reads are in flight and the buffer is empty. Then moves to DONE.
  - DONE: pulses done_o for one cycle, then returns to IDLE.
- Read address for offset k is (base + k) mod DEPTH; 4095 wraps to 0.
- Output buffer: a FIFO of depth READ_LAT+1, each entry {bit, addr, last}.
  - A read issues only when (FIFO count + reads in flight) < READ_LAT+1. This credit scheme means returning data is never dropped under backpressure.
  - Only the read for k = len−1 carries last = 1.
- Stream rules:
  - bit_o, bit_addr_o and bit_last_o hold stable while bit_valid_o=1 and bit_ready_i=0.
  - A beat transfers when bit_valid_o and bit_ready_i are both 1.
  - bit_valid_o never depends combinationally on bit_ready_i.
- abort_i in RUN or DRAIN: the next state is IDLE. The FIFO is flushed, in-flight data is discarded via a per-slot kill flag, and done_o is not pulsed. abort_i in IDLE is ignored.
- start_i outside IDLE is ignored. If start_i and abort_i are asserted together, abort wins.
- Reset values: all outputs 0, state IDLE, FIFO empty, in-flight count 0. Reset mid-scan behaves exactly like an abort, with no done_o and no err_o.

## Timing
- Start accepted at edge T. First mem_en_o=1 with mem_addr_o=base in cycle T+1.
- With bit_ready_i held at 1:
  - First bit_valid_o in cycle T+1+READ_LAT.
  - One beat per cycle thereafter; the last beat is in cycle T+READ_LAT+len.
  - done_o is asserted in the cycle after the last handshake.
  - busy_o is high from T+1 through the cycle of the last handshake.
- With bit_ready_i low, at most READ_LAT+1 bits are buffered and no further reads issue. Throughput returns to 1 bit/cycle one cycle after ready rises.
- err_o is asserted in cycle T+1 for a rejected start at T.

## Structure
- Package scan_pkg holds:
  - the state encoding as a one-hot localparam set: IDLE, RUN, DRAIN, DONE;
  - the FIFO entry field widths;
  - the legal READ_LAT range.
- One sub-module, scan_fifo: a parameterized synchronous FIFO (depth READ_LAT+1, count output, flush input).
- The top level holds the FSM, the offset counter, the in-flight tracking shift register (valid + kill per stage) and the credit check.

## Test plan
- base=0x010, len=5, ROM[0x10..0x14]=1,0,1,1,1, ready=1, READ_LAT=1 → bits 1,0,1,1,1 on consecutive cycles with addr 0x010..0x014. last=1 only on 0x014. done_o the following cycle.
- base=0xFFE, len=4 → addresses 0xFFE, 0xFFF, 0x000, 0x001 in order, data matching the ROM.
- len=16, READ_LAT=2, ready toggling 1,0,0,1 repeatedly → all 16 bits delivered in order with no loss or duplication. mem_en_o is never active while (FIFO count + in flight) = 3.
- len=0, then len=4097 → err_o pulses once for each request, busy_o stays 0, no mem_en_o.
- len=100, abort_i in cycle 20 → bit_valid_o is 0 from the next cycle, no done_o, and a new start is accepted two cycles later.
- rst=0 held for one cycle mid-scan → all outputs 0 on the next cycle. A subsequent scan with len=3 completes normally.

Source files
------------

// File: rtl/scan_sequencer_pkg.sv
// scan_pkg: shared state encoding, FIFO entry layout and read-latency limits for scan_sequencer.
package scan_pkg;
    localparam logic [3:0] S_IDLE  = 4'b0001;
    localparam logic [3:0] S_RUN   = 4'b0010;
    localparam logic [3:0] S_DRAIN = 4'b0100;
    localparam logic [3:0] S_DONE  = 4'b1000;
    localparam int BIT_W = 1;
    localparam int LAST_W = 1;
    localparam int READ_LAT_MIN = 1;
    localparam int READ_LAT_MAX = 2;
    localparam int OCC_W = 3;
    function automatic int entry_w(input int addr_w);
        return BIT_W + addr_w + LAST_W;
    endfunction
endpackage

// File: rtl/scan_sequencer_if.sv
// scan_sequencer_if: bit stream from the sequencer to the detector, each beat tagged with address and last.
interface scan_sequencer_if #(parameter int ADDR_W = 12);
    logic data;
    logic [ADDR_W-1:0] addr;
    logic last;
    logic valid;
    logic ready;
    modport master (output data, addr, last, valid, input ready);
    modport slave (input data, addr, last, valid, output ready);
endinterface

// File: rtl/scan_sequencer_fifo.sv
// scan_fifo: small synchronous FIFO with occupancy count and flush; the caller guarantees no overflow.
module scan_fifo #(
    parameter int W = 14,
    parameter int D = 2,
    parameter int CW = $clog2(D + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush_i,
    input  logic         wr_i,
    input  logic [W-1:0] wdata_i,
    input  logic         rd_i,
    output logic [W-1:0] rdata_o,
    output logic [CW-1:0] count_o
);
    localparam int PW = $clog2(D);
    logic [W-1:0] mem_q [D];
    logic [PW-1:0] wp_q, rp_q;
    logic [CW-1:0] cnt_q;
    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return p == PW'(D - 1) ? '0 : p + 1'b1;
    endfunction
    always_ff @(posedge clk) begin
        if (!rst || flush_i) begin
            wp_q <= '0;
            rp_q <= '0;
            cnt_q <= '0;
        end else begin
            if (wr_i) wp_q <= nxt(wp_q);
            if (rd_i) rp_q <= nxt(rp_q);
            cnt_q <= cnt_q + CW'(wr_i) - CW'(rd_i);
        end
    end
    always_ff @(posedge clk) begin
        if (wr_i) mem_q[wp_q] <= wdata_i;
    end
    assign rdata_o = mem_q[rp_q];
    assign count_o = cnt_q;
endmodule

// File: rtl/scan_sequencer.sv
// scan_sequencer: walks a ROM window, hides read latency with credit-limited reads, streams one bit per cycle.
module scan_sequencer import scan_pkg::*; #(
    parameter int ADDR_W = 12,
    parameter int DEPTH = 4096,
    parameter int READ_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [ADDR_W-1:0] base_i,
    input  logic [ADDR_W:0]   len_i,
    output logic              mem_en_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic              mem_data_i,
    scan_sequencer_if.master  bit_if,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o
);
    localparam int LAT = READ_LAT < READ_LAT_MIN ? READ_LAT_MIN :
                         (READ_LAT > READ_LAT_MAX ? READ_LAT_MAX : READ_LAT);
    localparam int FD = LAT + 1;
    localparam int EW = entry_w(ADDR_W);
    localparam int CW = $clog2(FD + 1);
    localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W + 1)'(DEPTH);
    logic [3:0] state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W:0] len_q, len_d, off_q, off_d;
    logic err_q, err_d;
    logic [LAT-1:0] vld_q, kill_q, last_q;
    logic [ADDR_W-1:0] addr_q [LAT];
    logic [CW-1:0] fifo_cnt;
    logic [EW-1:0] fifo_rdata, head;
    logic [OCC_W-1:0] occ;
    logic [ADDR_W:0] raw_addr;
    logic [ADDR_W-1:0] raddr;
    logic active, abort, issue, arr, empty, valid, hs, fifo_wr, fifo_rd;
    assign active = state_q == S_RUN || state_q == S_DRAIN;
    assign abort = abort_i && active;
    // occupancy = buffered beats plus every read still in the ROM pipeline (killed ones included)
    always_comb begin
        occ = OCC_W'(fifo_cnt);
        for (int i = 0; i < LAT; i++) occ = occ + OCC_W'(vld_q[i]);
    end
    assign issue = state_q == S_RUN && !abort_i && occ < OCC_W'(FD);
    assign raw_addr = {1'b0, base_q} + off_q;
    assign raddr = raw_addr >= DEPTH_V ? ADDR_W'(raw_addr - DEPTH_V) : raw_addr[ADDR_W-1:0];
    assign mem_en_o = issue;
    assign mem_addr_o = issue ? raddr : '0;
    assign arr = vld_q[LAT-1] && !kill_q[LAT-1];
    assign empty = fifo_cnt == '0;
    // an arriving read bypasses the empty FIFO so the first beat lands READ_LAT cycles after its read
    assign head = empty ? {mem_data_i, addr_q[LAT-1], last_q[LAT-1]} : fifo_rdata;
    assign valid = !empty || arr;
    assign hs = valid && bit_if.ready;
    assign fifo_wr = arr && !abort && !(empty && bit_if.ready);
    assign fifo_rd = hs && !empty;
    assign bit_if.valid = valid;
    assign {bit_if.data, bit_if.addr, bit_if.last} = valid ? head : '0;
    assign busy_o = active;
    assign done_o = state_q == S_DONE;
    assign err_o = err_q;
    scan_fifo #(.W(EW), .D(FD)) u_fifo (
        .clk(clk),
        .rst(rst),
        .flush_i(abort),
        .wr_i(fifo_wr),
        .wdata_i({mem_data_i, addr_q[LAT-1], last_q[LAT-1]}),
        .rd_i(fifo_rd),
        .rdata_o(fifo_rdata),
        .count_o(fifo_cnt)
    );
    always_comb begin
        state_d = state_q;
        base_d = base_q;
        len_d = len_q;
        off_d = off_q;
        err_d = 1'b0;
        if (abort) state_d = S_IDLE;
        else if (state_q == S_IDLE && start_i && !abort_i) begin
            if (len_i != '0 && len_i <= DEPTH_V) begin
                state_d = S_RUN;
                base_d = base_i;
                len_d = len_i;
                off_d = '0;
            end else err_d = 1'b1;
        end else if (issue) begin
            off_d = off_q + 1'b1;
            if (off_d == len_q) state_d = S_DRAIN;
        end else if (state_q == S_DRAIN && occ == OCC_W'(hs)) state_d = S_DONE;
        else if (state_q == S_DONE) state_d = S_IDLE;
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            err_q <= 1'b0;
            vld_q <= '0;
            kill_q <= '0;
        end else begin
            state_q <= state_d;
            err_q <= err_d;
            for (int i = LAT - 1; i > 0; i--) begin
                vld_q[i] <= vld_q[i-1];
                kill_q[i] <= kill_q[i-1] || abort;
            end
            vld_q[0] <= issue;
            kill_q[0] <= 1'b0;
        end
    end
    always_ff @(posedge clk) begin
        base_q <= base_d;
        len_q <= len_d;
        off_q <= off_d;
        for (int i = LAT - 1; i > 0; i--) begin
            addr_q[i] <= addr_q[i-1];
            last_q[i] <= last_q[i-1];
        end
        addr_q[0] <= raddr;
        last_q[0] <= (off_q + 1'b1) == len_q;
    end
endmodule

// File: tb/tb_scan_sequencer.sv
// tb_scan_sequencer: directed checks of two sequencers (READ_LAT 1 and 2) against a behavioural ROM.
module tb_scan_sequencer;
    logic clk = 1'b0, rst = 1'b0, start = 1'b0, abort = 1'b0, r1 = 1'b1, r2 = 1'b1;
    logic [11:0] base = '0;
    logic [12:0] len = '0;
    logic en1, en2, d1, p2, d2, busy1, busy2, done1, done2, err1, err2;
    logic [11:0] a1, a2;
    logic rom [4096];
    int errors = 0, checks = 0;
    scan_sequencer_if #(.ADDR_W(12)) s1 ();
    scan_sequencer_if #(.ADDR_W(12)) s2 ();
    assign s1.ready = r1;
    assign s2.ready = r2;
    scan_sequencer #(.ADDR_W(12), .DEPTH(4096), .READ_LAT(1)) dut1 (
        .clk(clk), .rst(rst), .start_i(start), .abort_i(abort), .base_i(base), .len_i(len),
        .mem_en_o(en1), .mem_addr_o(a1), .mem_data_i(d1), .bit_if(s1.master),
        .busy_o(busy1), .done_o(done1), .err_o(err1)
    );
    scan_sequencer #(.ADDR_W(12), .DEPTH(4096), .READ_LAT(2)) dut2 (
        .clk(clk), .rst(rst), .start_i(start), .abort_i(abort), .base_i(base), .len_i(len),
        .mem_en_o(en2), .mem_addr_o(a2), .mem_data_i(d2), .bit_if(s2.master),
        .busy_o(busy2), .done_o(done2), .err_o(err2)
    );
    always #5 clk = ~clk;
    always @(posedge clk) begin
        if (en1) d1 <= rom[a1];
        if (en2) p2 <= rom[a2];
        d2 <= p2;
    end
    typedef struct {
        logic st;
        logic [11:0] b;
        logic [12:0] l;
        logic [30:0] exp;
    } vec_t;
    vec_t tv [14];
    function automatic logic [30:0] o(input logic en, input logic [11:0] ma, input logic v, input logic bt,
                                      input logic [11:0] ba, input logic la, input logic bu, input logic dn,
                                      input logic er);
        return {en, ma, v, bt, ba, la, bu, dn, er};
    endfunction
    function automatic logic [30:0] out1();
        return o(en1, a1, s1.valid, s1.data, s1.addr, s1.last, busy1, done1, err1);
    endfunction
    function automatic logic [30:0] out2();
        return o(en2, a2, s2.valid, s2.data, s2.addr, s2.last, busy2, done2, err2);
    endfunction
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    task automatic run_scan(input bit s, input logic [11:0] b, input logic [12:0] n, input bit tog);
        int k = 0, iss = 0, over = 0, fv = -1, lc = -1, dc = -1;
        int cap = s ? 3 : 2;
        int lat = s ? 2 : 1;
        logic rdy, v, dat, lst, en, dn;
        logic [11:0] ad, ma, ea;
        @(negedge clk);
        start = 1'b1;
        base = b;
        len = n;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 400 && dc < 0; c++) begin
            rdy = tog ? (c % 4 == 0 || c % 4 == 3) : 1'b1;
            r1 = s ? 1'b1 : rdy;
            r2 = s ? rdy : 1'b1;
            #1;
            v = s ? s2.valid : s1.valid;
            dat = s ? s2.data : s1.data;
            ad = s ? s2.addr : s1.addr;
            lst = s ? s2.last : s1.last;
            en = s ? en2 : en1;
            ma = s ? a2 : a1;
            dn = s ? done2 : done1;
            if (c == 0) chk("first_read", {en, ma}, {1'b1, b});
            if (en && iss - k >= cap) over++;
            if (en) iss++;
            if (v && fv < 0) fv = c;
            if (dn) dc = c;
            if (v && rdy) begin
                ea = b + k[11:0];
                chk($sformatf("beat%0d@%h", k, b), {dat, ad, lst}, {rom[ea], ea, k == n - 1});
                lc = c;
                k++;
            end
            @(negedge clk);
        end
        r1 = 1'b1;
        r2 = 1'b1;
        chk("beat_count", k, n);
        chk("done_after_last", dc, lc + 1);
        chk("first_valid", fv, lat);
        chk("credit_limit", over, 0);
        if (!tog) chk("last_cycle", lc, lat + n - 1);
    endtask
    initial begin
        for (int i = 0; i < 4096; i++) rom[i] = 1'(((i * 13) >> 2) & 1);
        rom[16] = 1'b1; rom[17] = 1'b0; rom[18] = 1'b1; rom[19] = 1'b1; rom[20] = 1'b1;
        tv[0]  = '{1'b1, 12'h010, 13'd5,    o(0, 12'h000, 0, 0, 12'h000, 0, 0, 0, 0)};
        tv[1]  = '{1'b0, 12'h000, 13'd0,    o(1, 12'h010, 0, 0, 12'h000, 0, 1, 0, 0)};
        tv[2]  = '{1'b0, 12'h000, 13'd0,    o(1, 12'h011, 1, 1, 12'h010, 0, 1, 0, 0)};
        tv[3]  = '{1'b0, 12'h000, 13'd0,    o(1, 12'h012, 1, 0, 12'h011, 0, 1, 0, 0)};
        tv[4]  = '{1'b0, 12'h000, 13'd0,    o(1, 12'h013, 1, 1, 12'h012, 0, 1, 0, 0)};
        tv[5]  = '{1'b0, 12'h000, 13'd0,    o(1, 12'h014, 1, 1, 12'h013, 0, 1, 0, 0)};
        tv[6]  = '{1'b0, 12'h000, 13'd0,    o(0, 12'h000, 1, 1, 12'h014, 1, 1, 0, 0)};
        tv[7]  = '{1'b0, 12'h000, 13'd0,    o(0, 12'h000, 0, 0, 12'h000, 0, 0, 1, 0)};
        tv[8]  = '{1'b0, 12'h000, 13'd0,    o(0, 12'h000, 0, 0, 12'h000, 0, 0, 0, 0)};
        tv[9]  = '{1'b1, 12'h000, 13'd0,    o(0, 12'h000, 0, 0, 12'h000, 0, 0, 0, 0)};
        tv[10] = '{1'b0, 12'h000, 13'd0,    o(0, 12'h000, 0, 0, 12'h000, 0, 0, 0, 1)};
        tv[11] = '{1'b1, 12'h000, 13'd4097, o(0, 12'h000, 0, 0, 12'h000, 0, 0, 0, 0)};
        tv[12] = '{1'b0, 12'h000, 13'd0,    o(0, 12'h000, 0, 0, 12'h000, 0, 0, 0, 1)};
        tv[13] = '{1'b0, 12'h000, 13'd0,    o(0, 12'h000, 0, 0, 12'h000, 0, 0, 0, 0)};
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("reset_dut1", out1(), '0);
        chk("reset_dut2", out2(), '0);
        @(negedge clk);
        for (int i = 0; i < 14; i++) begin
            start = tv[i].st;
            if (tv[i].st) begin
                base = tv[i].b;
                len = tv[i].l;
            end
            #1;
            chk($sformatf("vec%0d", i), out1(), tv[i].exp);
            @(negedge clk);
        end
        start = 1'b0;
        repeat (3) @(negedge clk);
        run_scan(1'b0, 12'hFFE, 13'd4, 1'b0);
        repeat (4) @(negedge clk);
        run_scan(1'b1, 12'h3A5, 13'd16, 1'b1);
        repeat (6) @(negedge clk);
        start = 1'b1;
        base = 12'h200;
        len = 13'd100;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        abort = 1'b1;
        #1;
        chk("abort_cycle_valid", {s1.valid, busy1}, 2'b11);
        @(negedge clk);
        abort = 1'b0;
        #1;
        chk("after_abort_dut1", {s1.valid, busy1, en1, done1, err1}, '0);
        chk("after_abort_dut2", {s2.valid, busy2, en2, done2, err2}, '0);
        run_scan(1'b0, 12'h020, 13'd3, 1'b0);
        repeat (4) @(negedge clk);
        start = 1'b1;
        base = 12'h100;
        len = 13'd10;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midscan_reset_dut1", out1(), '0);
        chk("midscan_reset_dut2", out2(), '0);
        run_scan(1'b0, 12'h7F0, 13'd3, 1'b0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
